// File: rtl/menu_sequencer.sv
// Multi-stage menu sequencer. Four raw pushbuttons are debounced into single-cycle
// events, which walk N_STAGES menus of N_OPTS options and end in an ack handshake.

module menu_btn_debounce (
   input  logic clk,
   input  logic reset,
   input  logic tick_i,
   input  logic btn_i,
   output logic evt_o
);
   logic [1:0] sync_q;
   logic [1:0] hist_q;
   logic       evt_q;

   // A press is recognised when the tick samples go 0,1,1; the pulse lasts one clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= '0;
         evt_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         evt_q  <= 1'b0;
         if (tick_i) begin
            hist_q <= {hist_q[0], sync_q[1]};
            evt_q  <= (hist_q == 2'b01) && sync_q[1];
         end
      end
   end

   assign evt_o = evt_q;
endmodule

module menu_sequencer #(
   parameter int N_STAGES = 3,
   parameter int N_OPTS   = 4,
   parameter int TICK_DIV = 1 << 20,
   localparam int SW = (N_STAGES > 2) ? $clog2(N_STAGES) : 1,
   localparam int CW = (N_OPTS > 2) ? $clog2(N_OPTS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         btn_next,
   input  logic                         btn_prev,
   input  logic                         btn_sel,
   input  logic                         btn_cancel,
   input  logic                         ack,
   output logic [N_STAGES*N_OPTS-1:0]   opt_onehot,
   output logic [SW-1:0]                stage,
   output logic [CW-1:0]                cursor,
   output logic [N_STAGES*CW-1:0]       choices,
   output logic                         done
);
   localparam int NW = N_STAGES * N_OPTS;
   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);
   localparam logic [CW-1:0] LAST_OPT   = CW'(N_OPTS - 1);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

   localparam int EV_NEXT   = 0;
   localparam int EV_PREV   = 1;
   localparam int EV_SEL    = 2;
   localparam int EV_CANCEL = 3;

   typedef enum logic {ST_BROWSE = 1'b0, ST_DONE = 1'b1} state_t;

   state_t                          state_q, state_d;
   logic [SW-1:0]                   stage_q, stage_d;
   logic [CW-1:0]                   cursor_q, cursor_d;
   logic [N_STAGES-1:0][CW-1:0]     choices_q, choices_d;
   logic [NW-1:0]                   onehot_q, onehot_d;
   logic                            done_q, done_d;
   logic [TW-1:0]                   tick_cnt_q, tick_cnt_d;
   logic                            tick;
   logic [3:0]                      btn_raw;
   logic [3:0]                      evt;

   assign tick       = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

   assign btn_raw = {btn_cancel, btn_sel, btn_prev, btn_next};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      menu_btn_debounce u_db (
         .clk    (clk),
         .reset  (reset),
         .tick_i (tick),
         .btn_i  (btn_raw[g]),
         .evt_o  (evt[g])
      );
   end

   // Only the highest-priority event of a cycle acts: cancel > sel > prev > next.
   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      cursor_d  = cursor_q;
      choices_d = choices_q;
      unique case (state_q)
         ST_BROWSE: begin
            if (evt[EV_CANCEL]) begin
               if (stage_q != '0) begin
                  choices_d[stage_q] = '0;
                  stage_d            = stage_q - SW'(1);
                  cursor_d           = choices_q[stage_q - SW'(1)];
               end else begin
                  cursor_d  = '0;
                  choices_d = '0;
               end
            end else if (evt[EV_SEL]) begin
               choices_d[stage_q] = cursor_q;
               if (stage_q != LAST_STAGE) begin
                  stage_d  = stage_q + SW'(1);
                  cursor_d = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (evt[EV_PREV]) begin
               cursor_d = (cursor_q == '0) ? LAST_OPT : cursor_q - CW'(1);
            end else if (evt[EV_NEXT]) begin
               cursor_d = (cursor_q == LAST_OPT) ? '0 : cursor_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (ack) begin
               state_d   = ST_BROWSE;
               stage_d   = '0;
               cursor_d  = '0;
               choices_d = '0;
            end else if (evt[EV_CANCEL]) begin
               state_d  = ST_BROWSE;
               stage_d  = LAST_STAGE;
               cursor_d = choices_q[LAST_STAGE];
            end
         end
         default: state_d = ST_BROWSE;
      endcase
   end

   always_comb begin
      onehot_d = '0;
      done_d   = (state_d == ST_DONE);
      for (int s = 0; s < N_STAGES; s++) begin
         for (int o = 0; o < N_OPTS; o++) begin
            onehot_d[s*N_OPTS + o] = (state_d == ST_BROWSE) &&
                                     (stage_d == SW'(s)) && (cursor_d == CW'(o));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BROWSE;
         stage_q    <= '0;
         cursor_q   <= '0;
         choices_q  <= '0;
         onehot_q   <= NW'(1);
         done_q     <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         cursor_q   <= cursor_d;
         choices_q  <= choices_d;
         onehot_q   <= onehot_d;
         done_q     <= done_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign opt_onehot = onehot_q;
   assign stage      = stage_q;
   assign cursor     = cursor_q;
   assign choices    = choices_q;
   assign done       = done_q;
endmodule
